// File: rtl/data_mem_arbiter.sv
// Shares the byte-wide synchronous data RAM between the CPU load/store port and a DMA requester.
// The CPU has priority, but a burst counter hands the DMA one slot after CPU_BURST consecutive CPU grants.
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_stall,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic {C_IDLE, C_RD} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

    cpu_state_t        cpu_state, cpu_state_next;
    owner_t            rd_owner, rd_owner_next;
    logic [3:0]        burst_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        last_wdata;
    logic [7:0]        cpu_rdata_q;
    logic [7:0]        dma_rdata_q;
    logic              cpu_win, dma_win;

    // Winner selection; nothing is issued while reset is held so the RAM is never written then.
    always_comb begin
        cpu_win = reset && cpu_req && (cpu_state == C_IDLE)
                  && !(dma_req && (burst_cnt == BURST_MAX));
        dma_win = reset && dma_req && !cpu_win;
    end

    always_comb begin
        mem_we    = (cpu_win && cpu_we) || (dma_win && dma_we);
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_win) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign dma_gnt = dma_win;

    // Idle cycles keep the bus address/data stable at the last issued access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (cpu_win || dma_win) begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (!dma_req || dma_win) begin
            burst_cnt <= '0;
        end else if (cpu_win && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_state <= C_IDLE;
            rd_owner  <= OWN_NONE;
        end else begin
            cpu_state <= cpu_state_next;
            rd_owner  <= rd_owner_next;
        end
    end

    // A stalled store retries next cycle; a granted load stalls once while the RAM answers.
    always_comb begin
        cpu_state_next = cpu_state;
        cpu_stall      = 1'b0;
        unique case (cpu_state)
            C_IDLE: begin
                cpu_stall = cpu_req && (!cpu_win || !cpu_we);
                if (cpu_win && !cpu_we) begin
                    cpu_state_next = C_RD;
                end
            end
            C_RD: begin
                cpu_state_next = C_IDLE;
            end
            default: begin
                cpu_state_next = C_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (cpu_win && !cpu_we) begin
            rd_owner_next = OWN_CPU;
        end else if (dma_win && !dma_we) begin
            rd_owner_next = OWN_DMA;
        end
    end

    // Returning read data is bypassed straight through and also captured so it holds afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (rd_owner == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (rd_owner == OWN_DMA) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign dma_rvalid = (rd_owner == OWN_DMA);
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    assign cpu_rdata  = (rd_owner == OWN_CPU) ? mem_rdata : cpu_rdata_q;

endmodule
